// File: rtl/cg_enable_seq.sv
// cg_enable_seq: delayed fixed-width ENABLE burst sequencer for a latch clock gate; define CG_ENABLE_SEQ_REPEAT_EN for repeated bursts
module cg_enable_seq #(
  parameter int CNT_SIZE = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                ABORT,
  input  logic [CNT_SIZE-1:0] DELAY,
  input  logic [CNT_SIZE-1:0] WIDTH,
  input  logic [CNT_SIZE-1:0] REPEAT,
  output logic                ENABLE,
  output logic                BUSY,
  output logic                DONE,
  output logic [CNT_SIZE-1:0] PULSE_CNT
);
`ifdef CG_ENABLE_SEQ_REPEAT_EN
  typedef enum logic [2:0] {IDLE, WAIT, RUN, GAP, FIN} state_t;
  logic [CNT_SIZE-1:0] delay_q, rep, rep_n;
`else
  typedef enum logic [2:0] {IDLE, WAIT, RUN, FIN} state_t;
  logic unused_repeat;
  assign unused_repeat = ^REPEAT;
`endif
  localparam logic [CNT_SIZE-1:0] ONE = CNT_SIZE'(1);
  state_t state, state_n;
  logic [CNT_SIZE-1:0] cnt, cnt_n, width_q, pulse_base, pulse_n;
  logic ld;
  assign ld = state == IDLE && START && !ABORT;
  assign BUSY = state != IDLE;
  // next state: cnt is a down-counter that reloads on every phase change and exits at 1
  always_comb begin
    state_n = state;
    cnt_n = cnt;
`ifdef CG_ENABLE_SEQ_REPEAT_EN
    rep_n = rep;
`endif
    case (state)
      IDLE: if (ld) begin
        state_n = DELAY != '0 ? WAIT : WIDTH != '0 ? RUN : FIN;
        cnt_n = DELAY != '0 ? DELAY : WIDTH;
`ifdef CG_ENABLE_SEQ_REPEAT_EN
        rep_n = REPEAT != '0 ? REPEAT - ONE : '0;
`endif
      end
      WAIT: begin
        state_n = cnt != ONE ? WAIT : width_q != '0 ? RUN : FIN;
        cnt_n = cnt != ONE ? cnt - ONE : width_q;
      end
`ifdef CG_ENABLE_SEQ_REPEAT_EN
      RUN: if (cnt != ONE) cnt_n = cnt - ONE;
      else if (rep != '0) begin
        rep_n = rep - ONE;
        state_n = delay_q != '0 ? GAP : RUN;
        cnt_n = delay_q != '0 ? delay_q : width_q;
      end else state_n = FIN;
      GAP: begin
        state_n = cnt != ONE ? GAP : RUN;
        cnt_n = cnt != ONE ? cnt - ONE : width_q;
      end
`else
      RUN: begin
        state_n = cnt != ONE ? RUN : FIN;
        cnt_n = cnt - ONE;
      end
`endif
      default: state_n = IDLE;
    endcase
    if (ABORT && state != IDLE) state_n = IDLE;
    pulse_base = ld ? '0 : PULSE_CNT;
    pulse_n = (state_n == RUN && pulse_base != '1) ? pulse_base + ONE : pulse_base;
  end
  // state, counters and registered gate outputs; reset drops ENABLE without a clock
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      width_q <= '0;
      ENABLE <= 1'b0;
      DONE <= 1'b0;
      PULSE_CNT <= '0;
`ifdef CG_ENABLE_SEQ_REPEAT_EN
      delay_q <= '0;
      rep <= '0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ENABLE <= state_n == RUN;
      DONE <= state_n == FIN;
      PULSE_CNT <= pulse_n;
      if (ld) width_q <= WIDTH;
`ifdef CG_ENABLE_SEQ_REPEAT_EN
      if (ld) delay_q <= DELAY;
      rep <= rep_n;
`endif
    end
  end
endmodule

// File: tb/tb_cg_enable_seq.sv
// tb_cg_enable_seq: directed self-checking bench for cg_enable_seq
module tb_cg_enable_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [15:0] delay = '0, width = '0, rpt = '0;
  logic enable, busy, done;
  logic [15:0] pulse_cnt;
  int n_cmp = 0, n_fail = 0;

  cg_enable_seq dut (
    .CLK(clk), .RST(rst), .START(start), .ABORT(abort),
    .DELAY(delay), .WIDTH(width), .REPEAT(rpt),
    .ENABLE(enable), .BUSY(busy), .DONE(done), .PULSE_CNT(pulse_cnt)
  );

  always #5 clk = ~clk;

  // request accepted at the following rising edge t0; returns just after t0
  task automatic kick(input logic [15:0] d, input logic [15:0] w, input logic [15:0] r);
    @(negedge clk);
    delay = d; width = w; rpt = r; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({enable, busy, done, pulse_cnt} !== 19'b0) begin
      n_fail++;
      $display("FAIL reset_hold got en/busy/done/cnt=%b%b%b/%0d want 0000", enable, busy, done, pulse_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({enable, busy, done, pulse_cnt} !== 19'b0) begin
      n_fail++;
      $display("FAIL reset_idle got en/busy/done/cnt=%b%b%b/%0d want 0000", enable, busy, done, pulse_cnt);
    end
  endtask

  task automatic test_basic;
    logic [2:0] exp;
    kick(16'd3, 16'd5, 16'd1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      exp = {k >= 4 && k <= 8, k <= 9, k == 9};
      n_cmp++;
      if ({enable, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL basic k=%0d got en/busy/done=%b want %b", k, {enable, busy, done}, exp);
      end
      if (k == 9) begin
        n_cmp++;
        if (pulse_cnt !== 16'd5) begin
          n_fail++;
          $display("FAIL basic_cnt got %0d want 5", pulse_cnt);
        end
      end
    end
  endtask

  task automatic test_zero_delay;
    logic [2:0] exp;
    kick(16'd0, 16'd1, 16'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp = {k == 1, k <= 2, k == 2};
      n_cmp++;
      if ({enable, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL zero_delay k=%0d got en/busy/done=%b want %b", k, {enable, busy, done}, exp);
      end
    end
    n_cmp++;
    if (pulse_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL zero_delay_cnt got %0d want 1", pulse_cnt);
    end
  endtask

  task automatic test_zero_width;
    logic [2:0] exp;
    kick(16'd2, 16'd0, 16'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp = {1'b0, k <= 3, k == 3};
      n_cmp++;
      if ({enable, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL zero_width k=%0d got en/busy/done=%b want %b", k, {enable, busy, done}, exp);
      end
    end
    n_cmp++;
    if (pulse_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL zero_width_cnt got %0d want 0", pulse_cnt);
    end
  endtask

  task automatic test_busy_ignore;
    logic [2:0] exp;
    kick(16'd3, 16'd10, 16'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp = {k >= 4 && k <= 13, k <= 14, k == 14};
      n_cmp++;
      if ({enable, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL busy_ignore k=%0d got en/busy/done=%b want %b", k, {enable, busy, done}, exp);
      end
      if (k == 14) begin
        n_cmp++;
        if (pulse_cnt !== 16'd10) begin
          n_fail++;
          $display("FAIL busy_ignore_cnt got %0d want 10", pulse_cnt);
        end
      end
      start = k == 4;
      if (k == 4) begin
        width = 16'd2;
        delay = 16'd0;
      end
    end
  endtask

  task automatic test_abort;
    logic [2:0] exp;
    kick(16'd3, 16'd10, 16'd1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      exp = {k >= 4 && k <= 7, k <= 7, 1'b0};
      n_cmp++;
      if ({enable, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL abort k=%0d got en/busy/done=%b want %b", k, {enable, busy, done}, exp);
      end
      if (k == 8) begin
        n_cmp++;
        if (pulse_cnt !== 16'd4) begin
          n_fail++;
          $display("FAIL abort_cnt got %0d want 4", pulse_cnt);
        end
      end
      abort = k == 7;
    end
    abort = 1'b1;
    kick(16'd0, 16'd5, 16'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({enable, busy, done, pulse_cnt} !== {3'b000, 16'd4}) begin
        n_fail++;
        $display("FAIL abort_start k=%0d got en/busy/done=%b cnt=%0d want 000 cnt=4", k, {enable, busy, done}, pulse_cnt);
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_repeat;
    logic [2:0] exp;
    logic [9:0] en_pat;
    int done_k, want_cnt;
`ifdef CG_ENABLE_SEQ_REPEAT_EN
    en_pat = 10'b1101101100;
    done_k = 10;
    want_cnt = 6;
`else
    en_pat = 10'b0000001100;
    done_k = 4;
    want_cnt = 2;
`endif
    kick(16'd1, 16'd2, 16'd3);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp = {k <= 9 ? en_pat[k] : 1'b0, k <= done_k, k == done_k};
      n_cmp++;
      if ({enable, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL repeat k=%0d got en/busy/done=%b want %b", k, {enable, busy, done}, exp);
      end
    end
    n_cmp++;
    if (pulse_cnt !== 16'(want_cnt)) begin
      n_fail++;
      $display("FAIL repeat_cnt got %0d want %0d", pulse_cnt, want_cnt);
    end
  endtask

  task automatic test_async_reset;
    kick(16'd0, 16'd20, 16'd1);
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({enable, busy, pulse_cnt} !== {2'b11, 16'd5}) begin
      n_fail++;
      $display("FAIL mid_run got en/busy=%b cnt=%0d want 11 cnt=5", {enable, busy}, pulse_cnt);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({enable, busy, done, pulse_cnt} !== 19'b0) begin
      n_fail++;
      $display("FAIL async_reset got en/busy/done=%b cnt=%0d want 000 cnt=0", {enable, busy, done}, pulse_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_delay;
    test_zero_width;
    test_busy_ignore;
    test_abort;
    test_repeat;
    test_async_reset;
    test_basic;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
